ws2811_frame_buffer: RTL and testbench
======================================

Name: ws2811_frame_buffer

Overview:
- Double-buffered RGB pixel store that sits directly upstream of the WS2811 strip driver.
- Answers the driver's data_request/address with the colour for that LED one cycle later.
- A host-side write port fills a back bank. A swap request exchanges front and back banks only at a frame boundary, so the strip never shows a half-written frame.
- Both banks are cleared to black after reset.

Parameters:
NUM_LEDS, 49, pixel depth per bank; valid pixel addresses 0..NUM_LEDS-1
ADDR_WIDTH, 8, width of all pixel address ports
FRAME_CNT_WIDTH, 16, width of frame_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe, one pixel per cycle
wr_addr  in  ADDR_WIDTH  host pixel address (back bank)
wr_red  in  8  host red
wr_green  in  8  host green
wr_blue  in  8  host blue
swap_req  in  1  single-cycle pulse: request bank exchange at next frame start
swap_pending  out  1  swap accepted, not yet taken
swap_done  out  1  one-cycle pulse, cycle after the exchange
busy  out  1  post-reset clear in progress
frame_count  out  FRAME_CNT_WIDTH  frame starts since reset, wraps
data_request  in  1  from driver: pixel data is sampled on the following cycle
led_address  in  ADDR_WIDTH  driver's current LED address
red_out  out  8  registered red
green_out  out  8  registered green
blue_out  out  8  registered blue

Behaviour:
- The clock is clk. Reset is reset: synchronous, active-high.
- Reset values: swap_pending=0, swap_done=0, frame_count=0, red/green/blue_out=0, front bank index=0, busy=1, FSM=CLEAR, clear pointer=0.
- Storage: two banks, each NUM_LEDS x 24 bits. Read is synchronous; the write port and read port are independent.

FSM:
- CLEAR:
  - Each cycle, write 0 to pointer address in both banks, then pointer++.
  - When pointer == NUM_LEDS-1, that write completes and the FSM goes to IDLE.
  - busy is high for exactly NUM_LEDS cycles after reset deasserts.
- IDLE: normal operation. busy=0. IDLE is left only by reset.
- Reset asserted mid-CLEAR or mid-IDLE restarts CLEAR from pointer 0. Bank contents are not preserved.

Read path:
- On a cycle with data_request=1:
  - If led_address < NUM_LEDS and FSM=IDLE, the next cycle red/green/blue_out = front[led_address].
  - Otherwise the next cycle red/green/blue_out = 0 (black).
- Outputs hold their value when data_request=0.
- Latency is exactly 1 cycle.

Frame start:
- Frame start is defined as data_request=1 && led_address==0.
- Frame start increments frame_count (modulo 2^FRAME_CNT_WIDTH), including during CLEAR.

Swap handshake:
- swap_req=1 in IDLE sets swap_pending.
- swap_req while already pending has no effect.
- swap_req during CLEAR is ignored.
- On a frame start in IDLE with swap_pending=1:
  - Front index toggles, swap_pending clears, swap_done pulses on the next cycle.
  - The read issued on that same cycle uses the NEW front bank.
- swap_req on the same cycle as a frame start, with nothing pending, swaps immediately (same effect as above).

Write path:
- wr_en in IDLE with wr_addr < NUM_LEDS writes {wr_red, wr_green, wr_blue} to the back bank.
- The back bank is selected by the front index as registered at the start of the cycle. A write on the swap cycle therefore lands in the bank that was back before the swap, which is the new front.
- wr_addr >= NUM_LEDS is dropped.
- wr_en during CLEAR is dropped.
- Writes while swap_pending=1 are allowed.

Test Plan:
- Release reset; hold wr_en=1 throughout -> busy high for exactly 49 cycles. All outputs 0. A data_request for address 5 issued after busy falls returns 0,0,0.
- Write addr 3 = (0x12,0x34,0x56); pulse swap_req; issue data_request with address 0 (swap_done 1 cycle later); then data_request with address 3 -> outputs 0x12,0x34,0x56 the cycle after. frame_count increments by 1.
- Issue data_request with address 49 and with address 200 -> outputs 0 the next cycle. A write to address 60 does not alter any pixel.
- Raise swap_req in the same cycle as a frame start -> swap_pending stays 0, front toggles, swap_done the next cycle. A second swap_req while pending gives a single swap only.
- Write addr 3 = 0xFF,0,0 on the swap cycle -> after the swap, a read of addr 3 returns 0xFF,0,0.
- Assert reset mid-frame after writing addr 0 -> busy reasserts for 49 cycles, frame_count=0, a read of addr 0 returns 0.

Source files
------------

// File: rtl/ws2811_frame_buffer.sv
// rtl/ws2811_frame_buffer.sv - double-buffered RGB pixel store feeding the WS2811 strip driver
module ws2811_frame_buffer #(
  parameter int NUM_LEDS        = 49,
  parameter int ADDR_WIDTH      = 8,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [7:0]                 wr_red,
  input  logic [7:0]                 wr_green,
  input  logic [7:0]                 wr_blue,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       swap_done,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  input  logic                       data_request,
  input  logic [ADDR_WIDTH-1:0]      led_address,
  output logic [7:0]                 red_out,
  output logic [7:0]                 green_out,
  output logic [7:0]                 blue_out
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(NUM_LEDS);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  front;

  logic [23:0] bank0 [0:NUM_LEDS-1];
  logic [23:0] bank1 [0:NUM_LEDS-1];

  logic              frame_start;
  logic              swap_take;
  logic              front_next;
  logic              rd_ok;
  logic              wr_ok;
  logic              clearing;
  logic [IDX_W-1:0]  clr_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [23:0]       wr_word;
  logic [23:0]       rd_word;

  // Decode frame boundary, swap decision and the bank each port targets this cycle
  always_comb begin
    frame_start = data_request && (led_address == '0);
    swap_take   = (state == IDLE) && frame_start && (swap_pending || swap_req);
    // The read on the swap cycle already sees the new front bank
    front_next  = front ^ swap_take;
    rd_ok       = (state == IDLE) && (led_address < DEPTH);
    // Writes use the front index registered at cycle start, so a swap-cycle write lands in the new front
    wr_ok       = !reset && (state == IDLE) && wr_en && (wr_addr < DEPTH);
    clearing    = !reset && (state == CLEAR);
    clr_idx     = clr_ptr[IDX_W-1:0];
    wr_idx      = wr_addr[IDX_W-1:0];
    rd_idx      = led_address[IDX_W-1:0];
    wr_word     = {wr_red, wr_green, wr_blue};
    rd_word     = front_next ? bank1[rd_idx] : bank0[rd_idx];
  end

  // Bank 0: cleared after reset, written by the host while it is the back bank
  always_ff @(posedge clk) begin
    if (clearing) begin
      bank0[clr_idx] <= '0;
    end else if (wr_ok && front) begin
      bank0[wr_idx] <= wr_word;
    end
  end

  // Bank 1: cleared after reset, written by the host while it is the back bank
  always_ff @(posedge clk) begin
    if (clearing) begin
      bank1[clr_idx] <= '0;
    end else if (wr_ok && !front) begin
      bank1[wr_idx] <= wr_word;
    end
  end

  // Control FSM: post-reset clear, swap handshake, frame counter and registered pixel output
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_ptr      <= '0;
      busy         <= 1'b1;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      frame_count  <= '0;
      red_out      <= '0;
      green_out    <= '0;
      blue_out     <= '0;
    end else begin
      if (frame_start) begin
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      end

      swap_done <= swap_take;
      if (swap_take) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if ((state == IDLE) && swap_req) begin
        swap_pending <= 1'b1;
      end

      if (data_request) begin
        if (rd_ok) begin
          {red_out, green_out, blue_out} <= rd_word;
        end else begin
          {red_out, green_out, blue_out} <= '0;
        end
      end

      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_frame_buffer.sv
// tb/tb_ws2811_frame_buffer.sv - table-driven bench for ws2811_frame_buffer
module tb_ws2811_frame_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_red, wr_green, wr_blue;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_done;
  logic        busy;
  logic [15:0] frame_count;
  logic        data_request;
  logic [7:0]  led_address;
  logic [7:0]  red_out, green_out, blue_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ws2811_frame_buffer #(.NUM_LEDS(49), .ADDR_WIDTH(8), .FRAME_CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_red       (wr_red),
    .wr_green     (wr_green),
    .wr_blue      (wr_blue),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .busy         (busy),
    .frame_count  (frame_count),
    .data_request (data_request),
    .led_address  (led_address),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [23:0] wd;
    logic        sreq;
    logic        dreq;
    logic [7:0]  la;
    logic [23:0] exp_rgb;
    logic        exp_pend;
    logic        exp_done;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic we, logic [7:0] wa, logic [23:0] wd, logic sreq,
                              logic dreq, logic [7:0] la, logic [23:0] exp_rgb,
                              logic exp_pend, logic exp_done, logic [15:0] exp_fc);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.sreq = sreq; v.dreq = dreq; v.la = la;
    v.exp_rgb = exp_rgb; v.exp_pend = exp_pend; v.exp_done = exp_done; v.exp_fc = exp_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_red = '0; wr_green = '0; wr_blue = '0;
    swap_req = 1'b0; data_request = 1'b0; led_address = '0;
  endtask

  task automatic check_status(input string tag, input logic [23:0] rgb, input logic pend,
                              input logic done, input logic bsy, input logic [15:0] fc);
    check({tag, " rgb"},   {8'h0, red_out, green_out, blue_out}, {8'h0, rgb});
    check({tag, " pend"},  {31'h0, swap_pending}, {31'h0, pend});
    check({tag, " done"},  {31'h0, swap_done},    {31'h0, done});
    check({tag, " busy"},  {31'h0, busy},         {31'h0, bsy});
    check({tag, " fc"},    {16'h0, frame_count},  {16'h0, fc});
  endtask

  int busy_cycles;

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Expected behaviour after clear: front=bank0, back=bank1
    vecs[0]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd5,   24'h000000, 0, 0, 16'd0);
    vecs[1]  = mk(1, 8'd3,   24'h123456, 0, 0, 8'd0,   24'h000000, 0, 0, 16'd0);
    vecs[2]  = mk(1, 8'd60,  24'hABCDEF, 0, 0, 8'd0,   24'h000000, 0, 0, 16'd0);
    vecs[3]  = mk(0, 8'd0,   24'h0,      1, 0, 8'd0,   24'h000000, 1, 0, 16'd0);
    vecs[4]  = mk(1, 8'd10,  24'h0A0B0C, 1, 0, 8'd0,   24'h000000, 1, 0, 16'd0);
    vecs[5]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd0,   24'h000000, 0, 1, 16'd1);
    vecs[6]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd3,   24'h123456, 0, 0, 16'd1);
    vecs[7]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd10,  24'h0A0B0C, 0, 0, 16'd1);
    vecs[8]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd7,   24'h000000, 0, 0, 16'd1);
    vecs[9]  = mk(0, 8'd0,   24'h0,      0, 1, 8'd49,  24'h000000, 0, 0, 16'd1);
    vecs[10] = mk(0, 8'd0,   24'h0,      0, 1, 8'd3,   24'h123456, 0, 0, 16'd1);
    vecs[11] = mk(0, 8'd0,   24'h0,      0, 1, 8'd200, 24'h000000, 0, 0, 16'd1);
    vecs[12] = mk(0, 8'd0,   24'h0,      0, 1, 8'd3,   24'h123456, 0, 0, 16'd1);
    vecs[13] = mk(0, 8'd0,   24'h0,      0, 0, 8'd0,   24'h123456, 0, 0, 16'd1);
    vecs[14] = mk(1, 8'd3,   24'h111111, 0, 0, 8'd0,   24'h123456, 0, 0, 16'd1);
    vecs[15] = mk(1, 8'd3,   24'hFF0000, 1, 1, 8'd0,   24'h000000, 0, 1, 16'd2);
    vecs[16] = mk(0, 8'd0,   24'h0,      0, 1, 8'd3,   24'hFF0000, 0, 0, 16'd2);
    vecs[17] = mk(0, 8'd0,   24'h0,      0, 1, 8'd5,   24'h000000, 0, 0, 16'd2);

    step();
    step();
    check_status("reset", 24'h0, 0, 0, 1, 16'd0);

    // Hold a write during the clear; it must be dropped
    wr_en = 1'b1; wr_addr = 8'd7; {wr_red, wr_green, wr_blue} = 24'hAAAAAA;
    reset = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 200) begin
      step();
      busy_cycles++;
    end
    check("clear_len", busy_cycles, 49);
    idle_inputs();
    check_status("post_clear", 24'h0, 0, 0, 0, 16'd0);

    for (int i = 0; i < 18; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa;
      {wr_red, wr_green, wr_blue} = vecs[i].wd;
      swap_req = vecs[i].sreq; data_request = vecs[i].dreq; led_address = vecs[i].la;
      step();
      check_status($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_pend,
                   vecs[i].exp_done, 1'b0, vecs[i].exp_fc);
    end
    idle_inputs();

    // Write addr 0 into the back bank (bank1), swap it in, read it back
    wr_en = 1'b1; wr_addr = 8'd0; {wr_red, wr_green, wr_blue} = 24'h5A5A5A;
    step();
    idle_inputs();
    swap_req = 1'b1;
    step();
    idle_inputs();
    data_request = 1'b1; led_address = 8'd0;
    step();
    check("swap2_done", {31'h0, swap_done}, 32'd1);
    data_request = 1'b1; led_address = 8'd0;
    step();
    check("pre_reset_rd0", {8'h0, red_out, green_out, blue_out}, 32'h005A5A5A);
    check("pre_reset_fc", {16'h0, frame_count}, 32'd4);
    data_request = 1'b1; led_address = 8'd1;
    step();

    // Reset mid-frame
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_status("mid_reset", 24'h0, 0, 0, 1, 16'd0);

    // Frame start and swap request during clear: counted, not swapped
    data_request = 1'b1; led_address = 8'd0; swap_req = 1'b1;
    step();
    busy_cycles = 1;
    idle_inputs();
    check_status("clear_fs", 24'h0, 0, 0, 1, 16'd1);
    while (busy && busy_cycles < 200) begin
      step();
      busy_cycles++;
    end
    check("reclear_len", busy_cycles, 49);

    data_request = 1'b1; led_address = 8'd0;
    step();
    idle_inputs();
    check_status("post_reclear_rd0", 24'h0, 0, 0, 0, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
